// File: rtl/multicycle_control.sv
// Multicycle MIPS-I control unit: a seven-state FSM that sequences fetch, decode,
// execute, memory and write-back, with a memory wait timeout and a retired-instruction counter.
module multicycle_control #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32,
   parameter int EN_EXT  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             mem_ready,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             mem_req,
   output logic             mem_we,
   output logic             reg_write,
   output logic [3:0]       alu_op,
   output logic [2:0]       state,
   output logic             halt,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_LINK, C_SYS, C_ILL
   } cls_t;

   localparam logic [3:0] ALU_ADD  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SLTU = 4'b1100;
   localparam logic [3:0] ALU_SLL  = 4'b0000;
   localparam logic [3:0] ALU_SRL  = 4'b0010;
   localparam logic [3:0] ALU_SRA  = 4'b0001;

   state_t           r_state;
   state_t           w_next;
   cls_t             r_cls;
   cls_t             w_cls;
   logic [3:0]       r_alu;
   logic [3:0]       w_alu;
   logic [7:0]       r_wait;
   logic [CNT_W-1:0] r_retired;

   logic w_ir, w_pc, w_pcc, w_req, w_we, w_rw;
   logic w_wait_hit, w_retire, w_clear_wait;

   // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned (no latches).
   always_comb begin
      w_cls = C_ILL;
      w_alu = ALU_SLL;
      if (op == 6'h00) begin
         case (func)
            6'h20, 6'h21: begin w_cls = C_ALU;  w_alu = ALU_ADD;  end
            6'h22:        begin w_cls = C_ALU;  w_alu = ALU_SUB;  end
            6'h24:        begin w_cls = C_ALU;  w_alu = ALU_AND;  end
            6'h25:        begin w_cls = C_ALU;  w_alu = ALU_OR;   end
            6'h27:        begin w_cls = C_ALU;  w_alu = ALU_NOR;  end
            6'h2A:        begin w_cls = C_ALU;  w_alu = ALU_SLT;  end
            6'h2B:        begin w_cls = C_ALU;  w_alu = ALU_SLTU; end
            6'h00:        begin w_cls = C_ALU;  w_alu = ALU_SLL;  end
            6'h02:        begin w_cls = C_ALU;  w_alu = ALU_SRL;  end
            6'h03:        begin w_cls = C_ALU;  w_alu = ALU_SRA;  end
            6'h08:        begin w_cls = C_JUMP; w_alu = ALU_SLL;  end
            6'h0C:        w_cls = C_SYS;
            default:      w_cls = C_ILL;
         endcase
      end else begin
         case (op)
            6'h08, 6'h09: begin w_cls = C_ALU;    w_alu = ALU_ADD;  end
            6'h0C:        begin w_cls = C_ALU;    w_alu = ALU_AND;  end
            6'h0D:        begin w_cls = C_ALU;    w_alu = ALU_OR;   end
            6'h0A:        begin w_cls = C_ALU;    w_alu = ALU_SLT;  end
            6'h23:        begin w_cls = C_LOAD;   w_alu = ALU_ADD;  end
            6'h2B:        begin w_cls = C_STORE;  w_alu = ALU_ADD;  end
            6'h04, 6'h05: begin w_cls = C_BRANCH; w_alu = ALU_SUB;  end
            6'h02:        begin w_cls = C_JUMP;   w_alu = ALU_SLL;  end
            6'h03:        begin w_cls = C_LINK;   w_alu = ALU_SLL;  end
            default:      w_cls = C_ILL;
         endcase
         if (EN_EXT != 0) begin
            case (op)
               6'h0E:   begin w_cls = C_ALU;    w_alu = ALU_XOR;  end
               6'h0B:   begin w_cls = C_ALU;    w_alu = ALU_SLTU; end
               6'h29:   begin w_cls = C_STORE;  w_alu = ALU_ADD;  end
               6'h07:   begin w_cls = C_BRANCH; w_alu = ALU_SLT;  end
               default: ;
            endcase
         end
      end
   end

   // The wait counter counts the current cycle too, so the cycle holding TIMEOUT-1 is the last chance for mem_ready.
   assign w_wait_hit = (r_wait == 8'(TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      w_ir   = 1'b0;
      w_pc   = 1'b0;
      w_pcc  = 1'b0;
      w_req  = 1'b0;
      w_we   = 1'b0;
      w_rw   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_req = 1'b1;
            if (mem_ready) begin
               w_ir   = 1'b1;
               w_pc   = 1'b1;
               w_next = S_DECODE;
            end else if (w_wait_hit) begin
               w_next = S_ERR;
            end
         end
         S_DECODE: begin
            case (w_cls)
               C_SYS:   w_next = S_HALT;
               C_ILL:   w_next = S_ERR;
               default: w_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (r_cls)
               C_ALU:            w_next = S_WB;
               C_LOAD, C_STORE:  w_next = S_MEM;
               C_BRANCH: begin w_pcc = 1'b1; w_next = S_FETCH; end
               C_JUMP:   begin w_pc  = 1'b1; w_next = S_FETCH; end
               C_LINK:   begin w_pc  = 1'b1; w_rw = 1'b1; w_next = S_FETCH; end
               default:          w_next = S_ERR;
            endcase
         end
         S_MEM: begin
            w_req = 1'b1;
            w_we  = (r_cls == C_STORE);
            if (mem_ready) begin
               w_next = (r_cls == C_LOAD) ? S_WB : S_FETCH;
            end else if (w_wait_hit) begin
               w_next = S_ERR;
            end
         end
         S_WB: begin
            w_rw   = 1'b1;
            w_next = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         S_ERR:   w_next = S_ERR;
         default: w_next = S_ERR;
      endcase
   end

   assign w_retire     = (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) && (w_next == S_FETCH);
   assign w_clear_wait = (w_next != r_state) && (w_next == S_FETCH || w_next == S_MEM);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cls     <= C_ILL;
         r_alu     <= 4'b0000;
         r_wait    <= 8'd0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (w_clear_wait) begin
            r_wait <= 8'd0;
         end else if (w_req && !mem_ready) begin
            r_wait <= r_wait + 8'd1;
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
         if (r_state == S_DECODE) begin
            r_cls <= w_cls;
            r_alu <= w_alu;
         end
      end
   end

   // Strobes are masked while rst is high so a reset taken mid-MEM drops the request immediately.
   assign ir_write      = w_ir  & ~rst;
   assign pc_write      = w_pc  & ~rst;
   assign pc_write_cond = w_pcc & ~rst;
   assign mem_req       = w_req & ~rst;
   assign mem_we        = w_we  & ~rst;
   assign reg_write     = w_rw  & ~rst;
   assign alu_op        = (r_state == S_EXEC || r_state == S_MEM) ? r_alu : 4'b0000;
   assign state         = r_state;
   assign halt          = (r_state == S_HALT);
   assign err           = (r_state == S_ERR);
   assign retired       = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a default-parameter instance and a small one
// (TIMEOUT=4, CNT_W=4, EN_EXT=0) share stimulus; per-cycle expectations go through a queue.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] func;
   logic       mem_ready;

   logic        a_ir, a_pc, a_pcc, a_req, a_we, a_rw, a_halt, a_err;
   logic [3:0]  a_alu;
   logic [2:0]  a_state;
   logic [31:0] a_ret;
   logic        b_ir, b_pc, b_pcc, b_req, b_we, b_rw, b_halt, b_err;
   logic [3:0]  b_alu;
   logic [2:0]  b_state;
   logic [3:0]  b_ret;

   multicycle_control u_main (
      .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
      .ir_write(a_ir), .pc_write(a_pc), .pc_write_cond(a_pcc), .mem_req(a_req),
      .mem_we(a_we), .reg_write(a_rw), .alu_op(a_alu), .state(a_state),
      .halt(a_halt), .err(a_err), .retired(a_ret)
   );

   multicycle_control #(.TIMEOUT(4), .CNT_W(4), .EN_EXT(0)) u_small (
      .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
      .ir_write(b_ir), .pc_write(b_pc), .pc_write_cond(b_pcc), .mem_req(b_req),
      .mem_we(b_we), .reg_write(b_rw), .alu_op(b_alu), .state(b_state),
      .halt(b_halt), .err(b_err), .retired(b_ret)
   );

   always #5 clk = ~clk;

   // Strobe order: {ir_write, pc_write, pc_write_cond, mem_req, mem_we, reg_write}
   localparam logic [5:0] SB_NONE = 6'b000000;
   localparam logic [5:0] SB_ACK  = 6'b110100;
   localparam logic [5:0] SB_REQ  = 6'b000100;
   localparam logic [5:0] SB_WR   = 6'b000110;
   localparam logic [5:0] SB_WB   = 6'b000001;
   localparam logic [5:0] SB_BR   = 6'b001000;
   localparam logic [5:0] SB_J    = 6'b010000;
   localparam logic [5:0] SB_JAL  = 6'b010001;

   typedef struct packed {
      logic [14:0] ctl;
      logic [31:0] ret;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned n_ret    = 0;
   logic        sel      = 1'b0;
   string       cur_tag  = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic exp_t e(input logic [2:0] st, input logic [5:0] sb, input logic [3:0] alu,
                              input logic hl, input logic er);
      exp_t x;
      x.ctl = {st, sb, alu, hl, er};
      x.ret = sel ? (n_ret & 32'hF) : n_ret;
      return x;
   endfunction

   task automatic step(input exp_t x);
      exp_t        y;
      logic [14:0] obs_ctl;
      logic [31:0] obs_ret;
      exp_q.push_back(x);
      @(negedge clk);
      if (sel) begin
         obs_ctl = {b_state, b_ir, b_pc, b_pcc, b_req, b_we, b_rw, b_alu, b_halt, b_err};
         obs_ret = {28'd0, b_ret};
      end else begin
         obs_ctl = {a_state, a_ir, a_pc, a_pcc, a_req, a_we, a_rw, a_alu, a_halt, a_err};
         obs_ret = a_ret;
      end
      y = exp_q.pop_front();
      check({cur_tag, "/ctl"}, {17'd0, obs_ctl}, {17'd0, y.ctl});
      check({cur_tag, "/retired"}, obs_ret, y.ret);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      cur_tag   = "reset";
      rst       = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      n_ret = 0;
      step(e(3'd0, SB_NONE, 4'b0000, 1'b0, 1'b0));
      rst = 1'b0;
   endtask

   task automatic fetch_decode(input string tag, input logic [5:0] o, input logic [5:0] f);
      cur_tag   = tag;
      op        = o;
      func      = f;
      mem_ready = 1'b1;
      step(e(3'd0, SB_ACK, 4'b0000, 1'b0, 1'b0));
      mem_ready = 1'b0;
      step(e(3'd1, SB_NONE, 4'b0000, 1'b0, 1'b0));
   endtask

   task automatic do_alu(input string tag, input logic [5:0] o, input logic [5:0] f, input logic [3:0] alu);
      fetch_decode(tag, o, f);
      step(e(3'd2, SB_NONE, alu, 1'b0, 1'b0));
      step(e(3'd4, SB_WB, 4'b0000, 1'b0, 1'b0));
      n_ret++;
   endtask

   task automatic do_mem(input string tag, input logic [5:0] o, input logic wr, input int lat);
      fetch_decode(tag, o, 6'h00);
      step(e(3'd2, SB_NONE, 4'b0101, 1'b0, 1'b0));
      for (int i = 0; i < lat; i++) begin
         mem_ready = (i == lat - 1);
         step(e(3'd3, wr ? SB_WR : SB_REQ, 4'b0101, 1'b0, 1'b0));
      end
      mem_ready = 1'b0;
      if (!wr) step(e(3'd4, SB_WB, 4'b0000, 1'b0, 1'b0));
      n_ret++;
   endtask

   task automatic do_ctl(input string tag, input logic [5:0] o, input logic [5:0] f,
                         input logic [5:0] sb, input logic [3:0] alu);
      fetch_decode(tag, o, f);
      step(e(3'd2, sb, alu, 1'b0, 1'b0));
      n_ret++;
   endtask

   task automatic do_ill(input string tag, input logic [5:0] o, input logic [5:0] f);
      fetch_decode(tag, o, f);
      step(e(3'd6, SB_NONE, 4'b0000, 1'b0, 1'b1));
      step(e(3'd6, SB_NONE, 4'b0000, 1'b0, 1'b1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op = 6'h00; func = 6'h00; mem_ready = 1'b0;

      // Default-parameter instance: every instruction class
      sel = 1'b0;
      do_reset();
      do_alu("add", 6'h00, 6'h20, 4'b0101);
      do_mem("lw", 6'h23, 1'b0, 3);
      do_ctl("beq", 6'h04, 6'h00, SB_BR, 4'b0110);
      do_ctl("bne", 6'h05, 6'h00, SB_BR, 4'b0110);
      do_mem("sw", 6'h2B, 1'b1, 1);
      do_mem("sh", 6'h29, 1'b1, 2);
      do_ctl("j", 6'h02, 6'h00, SB_J, 4'b0000);
      do_ctl("jal", 6'h03, 6'h00, SB_JAL, 4'b0000);
      do_ctl("jr", 6'h00, 6'h08, SB_J, 4'b0000);
      do_ctl("bgtz", 6'h07, 6'h00, SB_BR, 4'b1011);
      do_alu("xori", 6'h0E, 6'h00, 4'b1001);
      do_alu("sltiu", 6'h0B, 6'h00, 4'b1100);
      do_alu("sub", 6'h00, 6'h22, 4'b0110);
      do_alu("and", 6'h00, 6'h24, 4'b0111);
      do_alu("or", 6'h00, 6'h25, 4'b1000);
      do_alu("nor", 6'h00, 6'h27, 4'b1010);
      do_alu("slt", 6'h00, 6'h2A, 4'b1011);
      do_alu("sltu", 6'h00, 6'h2B, 4'b1100);
      do_alu("sll", 6'h00, 6'h00, 4'b0000);
      do_alu("srl", 6'h00, 6'h02, 4'b0010);
      do_alu("sra", 6'h00, 6'h03, 4'b0001);
      do_alu("addi", 6'h08, 6'h00, 4'b0101);
      do_alu("andi", 6'h0C, 6'h00, 4'b0111);
      do_alu("ori", 6'h0D, 6'h00, 4'b1000);
      do_alu("slti", 6'h0A, 6'h00, 4'b1011);
      do_ill("subu_illegal", 6'h00, 6'h23);

      // Reset taken mid-MEM: request drops in the reset cycle, returns in FETCH
      do_reset();
      fetch_decode("rst_mid_mem", 6'h23, 6'h00);
      step(e(3'd2, SB_NONE, 4'b0101, 1'b0, 1'b0));
      step(e(3'd3, SB_REQ, 4'b0101, 1'b0, 1'b0));
      rst = 1'b1;
      step(e(3'd3, SB_NONE, 4'b0101, 1'b0, 1'b0));
      rst   = 1'b0;
      n_ret = 0;
      do_alu("post_rst_add", 6'h00, 6'h20, 4'b0101);

      // syscall: absorbing HALT, strobes stay low even with mem_ready toggling
      fetch_decode("syscall", 6'h00, 6'h0C);
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         step(e(3'd5, SB_NONE, 4'b0000, 1'b1, 1'b0));
      end
      do_reset();
      cur_tag = "after_halt";
      step(e(3'd0, SB_REQ, 4'b0000, 1'b0, 1'b0));

      // Small instance: fetch timeout, mem_ready on the last allowed cycle
      sel = 1'b1;
      do_reset();
      cur_tag = "fetch_timeout";
      for (int i = 0; i < 4; i++) step(e(3'd0, SB_REQ, 4'b0000, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) step(e(3'd6, SB_NONE, 4'b0000, 1'b0, 1'b1));

      do_reset();
      cur_tag = "ready_4th";
      op = 6'h00; func = 6'h20;
      for (int i = 0; i < 3; i++) step(e(3'd0, SB_REQ, 4'b0000, 1'b0, 1'b0));
      mem_ready = 1'b1;
      step(e(3'd0, SB_ACK, 4'b0000, 1'b0, 1'b0));
      mem_ready = 1'b0;
      step(e(3'd1, SB_NONE, 4'b0000, 1'b0, 1'b0));
      step(e(3'd2, SB_NONE, 4'b0101, 1'b0, 1'b0));
      step(e(3'd4, SB_WB, 4'b0000, 1'b0, 1'b0));
      n_ret++;
      do_ill("xori_no_ext", 6'h0E, 6'h00);

      do_reset();
      fetch_decode("mem_timeout", 6'h23, 6'h00);
      step(e(3'd2, SB_NONE, 4'b0101, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) step(e(3'd3, SB_REQ, 4'b0101, 1'b0, 1'b0));
      step(e(3'd6, SB_NONE, 4'b0000, 1'b0, 1'b1));

      // Retired counter wrap with CNT_W=4
      do_reset();
      for (int i = 0; i < 16; i++) do_alu("wrap_add", 6'h00, 6'h20, 4'b0101);
      cur_tag = "wrap_final";
      step(e(3'd0, SB_REQ, 4'b0000, 1'b0, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum mem_ready wait in cycles (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the retired-instruction counter width.
REQ-003 SHALL have parameter EN_EXT, default 1, meaning xori/sltiu/sh/bgtz are decoded when 1 and treated as illegal when 0.
REQ-004 SHALL have ports, one per line, as follows (clock and reset first).
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- op  in  6  opcode of the latched instruction register
- func  in  6  function field of the latched instruction register
- mem_ready  in  1  memory completion strobe, one cycle
- ir_write  out  1  latch the fetched word into IR
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if branch condition true (datapath evaluates)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- reg_write  out  1  register file write enable
- alu_op  out  4  ALU operation code
- state  out  3  current FSM state
- halt  out  1  syscall halt, sticky
- err  out  1  illegal opcode or memory timeout, sticky
- retired  out  CNT_W  retired instruction count

Function
REQ-005 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6; code 7 SHALL go to ERR.
REQ-006 FETCH SHALL assert mem_req=1 and mem_we=0. On mem_ready it SHALL pulse ir_write=1 and pc_write=1 in the same cycle and go to DECODE.
REQ-007 DECODE SHALL recognise add, addu, sub, and, or, nor, slt, sltu, sll, srl, sra, jr, syscall (op=0 with func), addi, addiu, andi, ori, slti, lw, sw, beq, bne, j, jal, plus xori, sltiu, sh and bgtz when EN_EXT=1, using standard MIPS-I encodings.
REQ-008 DECODE SHALL route syscall to HALT, any unrecognised op/func to ERR, and every other instruction to EXEC; it SHALL assert no strobes.
REQ-009 In EXEC, ALU-type instructions SHALL go to WB; lw, sw and sh SHALL go to MEM.
REQ-010 In EXEC, beq, bne and bgtz SHALL pulse pc_write_cond for 1 cycle and go to FETCH.
REQ-011 In EXEC, j and jr SHALL pulse pc_write and go to FETCH.
REQ-012 In EXEC, jal SHALL pulse pc_write and reg_write in the same cycle and go to FETCH.
REQ-013 MEM SHALL hold mem_req=1, with mem_we=1 for sw/sh and 0 for lw, until mem_ready. It SHALL then go to WB for lw and to FETCH for sw/sh.
REQ-014 WB SHALL pulse reg_write for 1 cycle and go to FETCH.
REQ-015 alu_op SHALL be driven in EXEC and MEM and SHALL be 0000 elsewhere.
REQ-016 alu_op encoding SHALL be as follows.
- add/addi/addiu/addu/lw/sw/sh: 0101
- sub/beq/bne: 0110
- and/andi: 0111
- or/ori: 1000
- nor: 1010
- sll/j/jal/jr: 0000
- srl: 0010
- sra: 0001
- slt/slti/bgtz: 1011
- sltu/sltiu: 1100
- xori: 1001
REQ-017 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 without mem_ready. When it reaches TIMEOUT, the FSM SHALL go to ERR on the next edge; mem_ready arriving in that same cycle SHALL win.
REQ-018 retired SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-019 HALT and ERR SHALL be absorbing until rst; halt=1 in HALT, err=1 in ERR, and all strobes SHALL be 0 in both.
REQ-020 All outputs SHALL be registered or decoded only from state and registered instruction class, so that no output depends combinationally on mem_ready except ir_write/pc_write in FETCH.

Reset
REQ-021 rst SHALL force state=FETCH, retired=0, wait counter=0, halt=0 and err=0, with all strobes 0 in the reset cycle.
REQ-022 rst SHALL take priority over every transition, including mid-MEM with mem_req high; mem_req SHALL be 1 again in the first post-reset cycle (FETCH).

Verification
REQ-023 Bench SHALL cover add (op=0, func=0x20) with mem_ready on the first request cycle: states 0,1,2,4,0; reg_write high exactly in WB; alu_op=0101 in EXEC; retired 0->1.
REQ-024 Bench SHALL cover lw (op=0x23) with 3-cycle MEM latency: mem_req high 3 cycles with mem_we=0; then WB reg_write; retired +1; total 5+2 cycles.
REQ-025 Bench SHALL cover beq (op=0x04): pc_write_cond=1 for exactly 1 cycle in EXEC, alu_op=0110, no reg_write, then return to FETCH.
REQ-026 Bench SHALL cover syscall (op=0, func=0x0C): halt=1 and state=5, held 20 cycles with no strobes; rst then gives state=0 and halt=0.
REQ-027 Bench SHALL cover TIMEOUT=4 with mem_ready never asserted in FETCH: err=1 and state=6 after 4 waiting cycles. A second run with mem_ready on the 4th cycle SHALL reach DECODE with no err.
REQ-028 Bench SHALL cover EN_EXT=0 with xori (op=0x0E): ERR after DECODE. Separately, CNT_W=4 SHALL show retired wrapping 15->0 on the 16th instruction.
